// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR stream generator.
package lfsr_pkg;

    typedef enum logic [1:0] {WARM, RUN, RECOVER} lfsr_state_e;

    localparam logic [9:0]  TAPS_10 = 10'h240;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    // Lock-up value, zero-extended to 32 bits: all-ones for XNOR, all-zeros for XOR.
    function automatic logic [31:0] lfsr_lockup_val(input int width, input logic mode);
        if (mode) begin
            return 32'hFFFF_FFFF >> (32 - width);
        end
        return 32'h0;
    endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational Fibonacci feedback: parity of tapped bits, optionally inverted, shifted in at bit 0.
module lfsr_feedback #(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = 10'h240
) (
    input  logic [WIDTH-1:0] state,
    input  logic             mode_xnor,
    output logic [WIDTH-1:0] next_state
);

    logic fb;

    assign fb         = (^(state & TAPS)) ^ mode_xnor;
    assign next_state = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_stream_gen.sv
// LFSR pseudo-random word stream with seed load and lock-up recovery.
// Period tracking (period_done/period_len) is built only when LFSR_PERIOD_CNT_EN is defined.
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 10,
    parameter logic [WIDTH-1:0] TAPS         = 10'h240,
    parameter logic [WIDTH-1:0] RECOVER_SEED = 10'h001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode_xnor,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    lfsr_state_e      fsm;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] step_state;
    logic [31:0]      lock_full;
    logic             is_lock;
    logic             step;

    lfsr_feedback #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_feedback (
        .state      (state),
        .mode_xnor  (mode_xnor),
        .next_state (step_state)
    );

    // A word is offered only in RUN and never while the state sits on the lock-up value.
    assign lock_full = lfsr_lockup_val(WIDTH, mode_xnor);
    assign is_lock   = (32'(state) == lock_full);
    assign out_valid = (fsm == RUN) && !is_lock;
    assign step      = out_valid && out_ready;
    assign out_data  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm    <= WARM;
            state  <= '0;
            lockup <= 1'b0;
        end else begin
            lockup <= 1'b0;
            if (seed_load) begin
                state <= seed_in;
                fsm   <= RUN;
            end else begin
                case (fsm)
                    WARM: fsm <= RUN;
                    RUN: begin
                        if (is_lock) begin
                            fsm    <= RECOVER;
                            lockup <= 1'b1;
                        end else if (out_ready) begin
                            state <= step_state;
                        end
                    end
                    RECOVER: begin
                        state <= RECOVER_SEED;
                        fsm   <= RUN;
                    end
                    default: fsm <= WARM;
                endcase
            end
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] ref_state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;

    // Saturating increment so a sequence that never returns cannot fake a period.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_state   <= '0;
            cnt         <= '0;
            period_len  <= '0;
            period_done <= 1'b0;
        end else begin
            period_done <= 1'b0;
            if (seed_load) begin
                ref_state <= seed_in;
                cnt       <= '0;
            end else if (fsm == RECOVER) begin
                ref_state <= RECOVER_SEED;
                cnt       <= '0;
            end else if (step) begin
                if (step_state == ref_state) begin
                    period_len  <= cnt_inc;
                    period_done <= 1'b1;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end
`else
    assign period_done = 1'b0;
    assign period_len  = '0;
`endif

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: directed scenarios plus a randomized run against a behavioural model.
module tb_lfsr_stream_gen;

    localparam int W = 10;
`ifdef LFSR_PERIOD_CNT_EN
    localparam bit PCNT = 1'b1;
`else
    localparam bit PCNT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mode_xnor = 1'b1;
    logic         seed_load = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         lockup;
    logic         period_done;
    logic [W-1:0] period_len;

    int n_checks = 0;
    int n_err = 0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];
    int pd_seen = 0;
    int lk_seen = 0;
    int last_plen = 0;

    // Reference model state: phase 0 = warm-up, 1 = streaming, 2 = recovering.
    int m_state, m_phase, m_ref, m_cnt, m_plen;
    bit m_lockup, m_pd;

    always #5 clk = ~clk;

    lfsr_stream_gen dut (
        .clk         (clk),
        .reset       (reset),
        .mode_xnor   (mode_xnor),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .lockup      (lockup),
        .period_done (period_done),
        .period_len  (period_len)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next word: shift left one place and append the parity of the tapped bits (plus one for XNOR).
    function automatic int m_next(input int s, input int mx);
        int ones;
        ones = $countones(s & 'h240);
        return (s * 2 + ((ones + mx) % 2)) % 1024;
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_ref = 0; m_cnt = 0; m_plen = 0;
        m_lockup = 1'b0; m_pd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; seed_load = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_lockup", 32'(lockup), 32'd0);
        chk("rst_pdone", 32'(period_done), 32'd0);
        chk("rst_plen", 32'(period_len), 32'd0);
        reset = 1'b0;
        model_reset();
        got_q.delete();
        pd_seen = 0; lk_seen = 0; last_plen = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic sl, input logic [W-1:0] si, input logic rdy, input logic mx);
        bit lock, n_lk, n_pd;
        int nxt, inc;
        seed_load = sl; seed_in = si; out_ready = rdy; mode_xnor = mx;
        #1;
        lock = mx ? (m_state == 1023) : (m_state == 0);
        chk("out_valid", 32'(out_valid), 32'(m_phase == 1 && !lock));
        chk("out_data", 32'(out_data), 32'(m_state));
        chk("lockup", 32'(lockup), 32'(m_lockup));
        chk("period_done", 32'(period_done), PCNT ? 32'(m_pd) : 32'd0);
        chk("period_len", 32'(period_len), PCNT ? 32'(m_plen) : 32'd0);
        if (out_valid && rdy) got_q.push_back(out_data);
        if (period_done) begin pd_seen++; last_plen = int'(period_len); end
        if (lockup) lk_seen++;
        n_lk = 1'b0; n_pd = 1'b0;
        if (sl) begin
            m_state = int'(si); m_phase = 1; m_ref = int'(si); m_cnt = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (lock) begin
                m_phase = 2; n_lk = 1'b1;
            end else if (rdy) begin
                nxt = m_next(m_state, int'(mx));
                inc = (m_cnt == 1023) ? 1023 : m_cnt + 1;
                if (nxt == m_ref) begin m_plen = inc; n_pd = 1'b1; m_cnt = 0; end
                else m_cnt = inc;
                m_state = nxt;
            end
        end else begin
            m_state = 1; m_ref = 1; m_cnt = 0; m_phase = 1;
        end
        m_lockup = n_lk; m_pd = n_pd;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic cmp_got(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        // XNOR stream from reset up to 0FE, then reset mid-stream.
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        #1;
        chk("at_0fe", 32'(out_data), 32'h0FE);
        exp_q = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F};
        cmp_got("xnor_seq");
        do_reset();

        // Back-pressure while 003 is on offer.
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_data", 32'(out_data), 32'h003);
            chk("hold_valid", 32'(out_valid), 32'd1);
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        exp_q = '{10'h000, 10'h001, 10'h003, 10'h007};
        cmp_got("stall_seq");

        // XOR from reset: state 0 is the lock-up value.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("xor_lockups", 32'(lk_seen), 32'd1);
        exp_q = '{10'h001, 10'h002, 10'h004, 10'h008};
        cmp_got("xor_seq");

        // Seed 3FF under XNOR coinciding with a handshake.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 10'h3FF, 1'b1, 1'b1);
        #1;
        chk("seed_data", 32'(out_data), 32'h3FF);
        chk("seed_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        #1;
        chk("seed_lockup", 32'(lockup), 32'd1);
        chk("seed_rec_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        #1;
        chk("seed_recovered", 32'(out_data), 32'h001);
        chk("seed_rec_lockup", 32'(lockup), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        exp_q = '{10'h000, 10'h001, 10'h003, 10'h001};
        cmp_got("seed_seq");

        // Full period free-run under XNOR.
        do_reset();
        for (int i = 0; i < 1030; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("period_pulses", 32'(pd_seen), PCNT ? 32'd1 : 32'd0);
        chk("period_value", 32'(last_plen), PCNT ? 32'h3FF : 32'd0);

        // Randomized traffic.
        do_reset();
        begin
            logic mx, sl, rdy;
            logic [W-1:0] si;
            mx = 1'b1;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 99) == 0) mx = ~mx;
                sl  = ($urandom_range(0, 29) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0: si = 10'h3FF;
                    1: si = 10'h000;
                    default: si = W'($urandom_range(0, 1023));
                endcase
                cycle(sl, si, rdy, mx);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
